neuron_config_loader: RTL and testbench
=======================================

NEURON_CONFIG_LOADER -- requirements
Module: neuron_config_loader

Interface
REQ-001 SHALL have parameter M, default 2, meaning the number of neuron inputs configured.
REQ-002 SHALL have localparam CFG_W = M*6+6 (config bits) and NBYTES = ceil(CFG_W/8); for M=2, CFG_W=18 and NBYTES=3.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cfg_data  input  8  configuration byte.
REQ-006 cfg_valid  input  1  cfg_data valid this cycle.
REQ-007 cfg_ready  output  1  loader accepts a byte this cycle.
REQ-008 cfg_abort  input  1  discard the partial load.
REQ-009 commit_en  input  1  safe window for applying the new configuration.
REQ-010 weights  output  M*2  active weights, to the delayed neuron.
REQ-011 delay_values  output  M*3  active 3-bit delay values.
REQ-012 delays  output  M  active per-input delay enables.
REQ-013 threshold, decay, refractory_period  output  2 each  active neuron constants.
REQ-014 neuron_enable  output  1  high once any configuration has been committed.
REQ-015 cfg_done  output  1  one-cycle pulse on commit.

Function
REQ-016 The FSM SHALL use states IDLE, LOAD and PEND: IDLE->LOAD on the first accepted byte; LOAD->PEND on byte NBYTES; PEND->IDLE on commit.
REQ-017 A byte SHALL be accepted exactly when cfg_valid and cfg_ready are both high; cfg_ready is high in IDLE and LOAD and low in PEND.
REQ-018 Accepted bytes SHALL fill a shadow register LSB-first: byte k goes to shadow bits [8k+7:8k]; bits at or above CFG_W are dropped.
REQ-019 The shadow bit map SHALL be, from LSB upward:
- weights[M*2-1:0]
- delay_values[M*3-1:0]
- delays[M-1:0]
- threshold
- decay
- refractory_period
REQ-020 The byte counter SHALL be ceil(log2(NBYTES+1)) bits wide and SHALL clear on commit, abort and reset.
REQ-021 In PEND, on the first cycle with commit_en high, all active output registers SHALL load from the shadow together in that single cycle.
- Outputs change on the edge ending that cycle.
- cfg_done pulses high for exactly the following cycle.
- neuron_enable is set to 1 and stays 1 until reset.
REQ-022 Active outputs SHALL never change except on commit or reset, so no partial configuration is ever visible.
REQ-023 cfg_abort in IDLE or LOAD SHALL return the FSM to IDLE and clear the counter; the shadow contents are don't-care and active outputs are unchanged.
REQ-024 cfg_abort in PEND SHALL return the FSM to IDLE without committing, and SHALL take priority over a simultaneous commit_en.
REQ-025 cfg_abort with a simultaneous cfg_valid SHALL discard the byte.
REQ-026 commit_en outside PEND SHALL have no effect.
REQ-027 PEND SHALL wait indefinitely for commit_en, with no timeout.
REQ-028 A new load MAY begin in the cycle after commit, because cfg_ready rises on entry to IDLE.

Reset
REQ-029 While reset is low at a clock edge, the block SHALL reset to:
- FSM in IDLE, counter 0, shadow all zeros.
- All active configuration outputs 0.
- neuron_enable 0 and cfg_done 0.
- cfg_ready 1 from the first cycle after reset is released.
REQ-030 Reset asserted mid-LOAD or in PEND SHALL discard the load with no commit.

Structure
REQ-031 The shared package snn_cfg_pkg SHALL hold:
- the IDLE/LOAD/PEND state enumeration;
- CFG_BYTE_W = 8;
- the functions computing CFG_W(M) and NBYTES(M).
REQ-032 The shadow register plus byte counter SHALL be one sub-module, cfg_byte_shifter; the FSM and active registers live in the top level.

Verification (M=2)
REQ-033 Load and commit: bytes 0xA5, 0x3C, 0x02, then commit_en.
- Expected: weights=4'b0101, delay_values=6'h0A, delays=2'b11, threshold=2'b11, decay=2'b00, refractory_period=2'b10.
- cfg_done pulses once; neuron_enable=1.
REQ-034 Hold in PEND: load 3 bytes with commit_en low for 20 cycles.
- Expected: outputs unchanged and cfg_ready=0 throughout; commit occurs on the first cycle commit_en goes high.
REQ-035 Abort mid-load: 2 bytes, then cfg_abort, then bytes 0xFF, 0xFF, 0x03 and commit.
- Expected: all active fields all-ones, with no contamination from the first two bytes.
REQ-036 Abort priority: assert cfg_abort and commit_en together in PEND.
- Expected: no commit, cfg_done stays 0, FSM returns to IDLE.
REQ-037 Reset mid-operation: reset low mid-LOAD after a prior commit.
- Expected: all outputs 0, neuron_enable=0, cfg_ready=1 after release.
REQ-038 Backpressure: hold cfg_valid high continuously with 4 bytes offered.
- Expected: exactly 3 bytes accepted; the 4th waits until after commit and becomes byte 0 of the next load.

Source files
------------

// File: rtl/snn_cfg_pkg.sv
// Shared definitions for the neuron configuration loader: loader FSM states,
// configuration byte width and the helpers that size the configuration image.
package snn_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } cfg_state_t;

    localparam int CFG_BYTE_W = 8;

    // Configuration image width: 5 bits per input (2-bit weight, 3-bit delay
    // value), 1 enable bit per input, plus three 2-bit neuron constants.
    function automatic int cfg_width(input int m);
        return m * 6 + 6;
    endfunction

    // Number of bytes needed to carry the configuration image.
    function automatic int cfg_nbytes(input int m);
        return (cfg_width(m) + CFG_BYTE_W - 1) / CFG_BYTE_W;
    endfunction

endpackage

// File: rtl/cfg_byte_shifter.sv
// Shadow register and byte counter. Accepted bytes land LSB-first at the slot
// selected by the counter; bits beyond the configuration width are dropped.
module cfg_byte_shifter
    import snn_cfg_pkg::*;
#(
    parameter int M = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [CFG_BYTE_W-1:0]                         byte_in,
    input  logic                                          accept,
    input  logic                                          clear,
    output logic [cfg_width(M)-1:0]                       shadow,
    output logic [$clog2(cfg_nbytes(M)+1)-1:0]            count
);

    localparam int CFG_W  = cfg_width(M);
    localparam int NBYTES = cfg_nbytes(M);
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [CFG_W-1:0]  shadow_r;
    logic [CFG_W-1:0]  shadow_next_s;
    logic [CNT_W-1:0]  count_r;
    logic [NBYTES-1:0] byte_hit_s;

    // One-hot decode of the byte slot the next accepted byte will fill.
    for (genvar k = 0; k < NBYTES; k++) begin : g_byte_hit
        assign byte_hit_s[k] = (count_r == CNT_W'(k));
    end

    // Per-bit next value: overwrite only the bits of the currently addressed byte.
    for (genvar b = 0; b < CFG_W; b++) begin : g_shadow_bit
        assign shadow_next_s[b] = (accept && byte_hit_s[b / CFG_BYTE_W])
                                  ? byte_in[b % CFG_BYTE_W]
                                  : shadow_r[b];
    end

    // Shadow register: zeroed on reset, otherwise follows the byte writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_r <= '0;
        end else begin
            shadow_r <= shadow_next_s;
        end
    end

    // Byte counter: clears on commit/abort, saturates once the image is full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (accept && (count_r != CNT_W'(NBYTES))) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign shadow = shadow_r;
    assign count  = count_r;

endmodule

// File: rtl/neuron_config_loader.sv
// Neuron configuration loader: collects a configuration image byte by byte
// into a shadow register and applies it atomically to the active neuron
// configuration when the commit window opens.
module neuron_config_loader
    import snn_cfg_pkg::*;
#(
    parameter int M = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_abort,
    input  logic              commit_en,
    output logic [M*2-1:0]    weights,
    output logic [M*3-1:0]    delay_values,
    output logic [M-1:0]      delays,
    output logic [1:0]        threshold,
    output logic [1:0]        decay,
    output logic [1:0]        refractory_period,
    output logic              neuron_enable,
    output logic              cfg_done
);

    localparam int CFG_W  = cfg_width(M);
    localparam int NBYTES = cfg_nbytes(M);
    localparam int CNT_W  = $clog2(NBYTES + 1);

    // Field offsets inside the shadow image, LSB upward.
    localparam int DV_LO  = M * 2;
    localparam int DE_LO  = M * 5;
    localparam int TH_LO  = M * 6;
    localparam int DC_LO  = M * 6 + 2;
    localparam int RP_LO  = M * 6 + 4;

    cfg_state_t        state_r;
    cfg_state_t        next_state_s;
    logic              accept_s;
    logic              commit_s;
    logic              clear_s;
    logic              last_byte_s;
    logic [CFG_W-1:0]  shadow_s;
    logic [CNT_W-1:0]  byte_count_s;

    logic              cfg_ready_r;
    logic [M*2-1:0]    weights_r;
    logic [M*3-1:0]    delay_values_r;
    logic [M-1:0]      delays_r;
    logic [1:0]        threshold_r;
    logic [1:0]        decay_r;
    logic [1:0]        refractory_period_r;
    logic              neuron_enable_r;
    logic              cfg_done_r;

    cfg_byte_shifter #(
        .M (M)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .byte_in (cfg_data),
        .accept  (accept_s),
        .clear   (clear_s),
        .shadow  (shadow_s),
        .count   (byte_count_s)
    );

    // An abort in the same cycle as a valid byte discards that byte.
    assign accept_s    = cfg_valid && cfg_ready_r && !cfg_abort;
    assign last_byte_s = (byte_count_s == CNT_W'(NBYTES - 1));

    // Loader FSM next state, commit strobe and counter clear.
    always_comb begin
        next_state_s = state_r;
        commit_s     = 1'b0;
        clear_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_abort) begin
                    next_state_s = IDLE;
                    clear_s      = 1'b1;
                end else if (accept_s) begin
                    if (last_byte_s) begin
                        next_state_s = PEND;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    next_state_s = IDLE;
                    clear_s      = 1'b1;
                end else if (accept_s && last_byte_s) begin
                    next_state_s = PEND;
                end else begin
                    next_state_s = LOAD;
                end
            end
            PEND: begin
                // Abort wins over a simultaneous commit window.
                if (cfg_abort) begin
                    next_state_s = IDLE;
                    clear_s      = 1'b1;
                end else if (commit_en) begin
                    next_state_s = IDLE;
                    commit_s     = 1'b1;
                    clear_s      = 1'b1;
                end else begin
                    next_state_s = PEND;
                end
            end
            default: begin
                next_state_s = IDLE;
                clear_s      = 1'b1;
            end
        endcase
    end

    // State register plus registered ready, which is high whenever not in PEND.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cfg_ready_r <= 1'b1;
        end else begin
            state_r     <= next_state_s;
            cfg_ready_r <= (next_state_s != PEND);
        end
    end

    // Active configuration: changes only on commit or reset, all fields together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            weights_r           <= '0;
            delay_values_r      <= '0;
            delays_r            <= '0;
            threshold_r         <= 2'b00;
            decay_r             <= 2'b00;
            refractory_period_r <= 2'b00;
        end else if (commit_s) begin
            weights_r           <= shadow_s[DV_LO-1:0];
            delay_values_r      <= shadow_s[DE_LO-1:DV_LO];
            delays_r            <= shadow_s[TH_LO-1:DE_LO];
            threshold_r         <= shadow_s[DC_LO-1:TH_LO];
            decay_r             <= shadow_s[RP_LO-1:DC_LO];
            refractory_period_r <= shadow_s[CFG_W-1:RP_LO];
        end else begin
            weights_r           <= weights_r;
            delay_values_r      <= delay_values_r;
            delays_r            <= delays_r;
            threshold_r         <= threshold_r;
            decay_r             <= decay_r;
            refractory_period_r <= refractory_period_r;
        end
    end

    // Commit status: one-cycle done pulse and a sticky enable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_done_r      <= 1'b0;
            neuron_enable_r <= 1'b0;
        end else begin
            cfg_done_r      <= commit_s;
            neuron_enable_r <= neuron_enable_r | commit_s;
        end
    end

    assign cfg_ready         = cfg_ready_r;
    assign weights           = weights_r;
    assign delay_values      = delay_values_r;
    assign delays            = delays_r;
    assign threshold         = threshold_r;
    assign decay             = decay_r;
    assign refractory_period = refractory_period_r;
    assign neuron_enable     = neuron_enable_r;
    assign cfg_done          = cfg_done_r;

endmodule

// File: tb/tb_neuron_config_loader.sv
// Directed self-checking bench for neuron_config_loader (M=2).
module tb_neuron_config_loader;

    logic       clk;
    logic       reset;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_abort;
    logic       commit_en;
    logic [3:0] weights;
    logic [5:0] delay_values;
    logic [1:0] delays;
    logic [1:0] threshold;
    logic [1:0] decay;
    logic [1:0] refractory_period;
    logic       neuron_enable;
    logic       cfg_done;

    int checks;
    int failures;

    logic [17:0] obs_all;
    assign obs_all = {refractory_period, decay, threshold, delays, delay_values, weights};

    neuron_config_loader #(.M(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_data          (cfg_data),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_abort         (cfg_abort),
        .commit_en         (commit_en),
        .weights           (weights),
        .delay_values      (delay_values),
        .delays            (delays),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .neuron_enable     (neuron_enable),
        .cfg_done          (cfg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cfg_valid = 1'b1;
        cfg_data  = b;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        cfg_data  = 8'h00;
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        commit_en = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_fields", 32'(obs_all), 32'h0);
        chk("rst_enable", 32'(neuron_enable), 32'h0);
        chk("rst_done", 32'(cfg_done), 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 32'(cfg_ready), 32'h1);

        // Load A5 3C 02 and commit
        send_byte(8'hA5);
        send_byte(8'h3C);
        chk("load_ready_mid", 32'(cfg_ready), 32'h1);
        send_byte(8'h02);
        chk("pend_ready", 32'(cfg_ready), 32'h0);
        chk("pend_no_change", 32'(obs_all), 32'h0);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("c1_weights", 32'(weights), 32'h5);
        chk("c1_delay_values", 32'(delay_values), 32'h0A);
        chk("c1_delays", 32'(delays), 32'h3);
        chk("c1_threshold", 32'(threshold), 32'h3);
        chk("c1_decay", 32'(decay), 32'h0);
        chk("c1_refractory", 32'(refractory_period), 32'h2);
        chk("c1_done", 32'(cfg_done), 32'h1);
        chk("c1_enable", 32'(neuron_enable), 32'h1);
        tick();
        chk("c1_done_drop", 32'(cfg_done), 32'h0);
        chk("c1_ready_back", 32'(cfg_ready), 32'h1);

        // Hold in PEND for 20 cycles, then commit 0x32211
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h03);
        for (int i = 0; i < 20; i++) begin
            chk("hold_ready", 32'(cfg_ready), 32'h0);
            chk("hold_fields", 32'(obs_all), 32'h23CA5);
            chk("hold_done", 32'(cfg_done), 32'h0);
            tick();
        end
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("c2_fields", 32'(obs_all), 32'h32211);
        chk("c2_done", 32'(cfg_done), 32'h1);
        tick();

        // Abort mid-load, with a valid byte in the abort cycle, then reload all-ones
        send_byte(8'h12);
        send_byte(8'h34);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h00;
        tick();
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_ready", 32'(cfg_ready), 32'h1);
        chk("abort_fields", 32'(obs_all), 32'h32211);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h03);
        chk("abort_pend", 32'(cfg_ready), 32'h0);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("c3_fields", 32'(obs_all), 32'h3FFFF);
        chk("c3_done", 32'(cfg_done), 32'h1);
        tick();

        // Abort and commit together in PEND: abort wins
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        cfg_abort = 1'b1;
        commit_en = 1'b1;
        tick();
        cfg_abort = 1'b0;
        commit_en = 1'b0;
        chk("prio_done", 32'(cfg_done), 32'h0);
        chk("prio_fields", 32'(obs_all), 32'h3FFFF);
        chk("prio_ready", 32'(cfg_ready), 32'h1);

        // Commit window outside PEND is ignored
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("idle_commit_done", 32'(cfg_done), 32'h0);
        chk("idle_commit_fields", 32'(obs_all), 32'h3FFFF);

        // Backpressure: four bytes offered back to back, only three taken
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        tick();
        cfg_data  = 8'hC3;
        tick();
        cfg_data  = 8'h01;
        tick();
        cfg_data  = 8'hE7;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 32'(cfg_ready), 32'h0);
            tick();
        end
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("bp_c_fields", 32'(obs_all), 32'h1C35A);
        chk("bp_c_done", 32'(cfg_done), 32'h1);
        chk("bp_c_ready", 32'(cfg_ready), 32'h1);
        tick();
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        chk("bp_done_once", 32'(cfg_done), 32'h0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("bp_pend", 32'(cfg_ready), 32'h0);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("bp_next_fields", 32'(obs_all), 32'h000E7);
        tick();

        // Reset mid-load after a prior commit
        send_byte(8'h77);
        reset = 1'b0;
        tick();
        chk("mrst_fields", 32'(obs_all), 32'h0);
        chk("mrst_enable", 32'(neuron_enable), 32'h0);
        chk("mrst_done", 32'(cfg_done), 32'h0);
        reset = 1'b1;
        tick();
        chk("mrst_ready", 32'(cfg_ready), 32'h1);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h03);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("mrst_reload", 32'(obs_all), 32'h3FFFF);
        chk("mrst_enable_again", 32'(neuron_enable), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
